// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN streaming controllers: controller state
// encoding and the width helper used by every image-geometry counter.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } ctrl_state_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster-order (row, col) position counter. Tracks the pixel currently being
// accepted; 'last' marks the final pixel of the frame. Reused by the pooling
// controller, so it knows nothing about windows.
module raster_pos_counter
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    localparam int COL_W     = cnt_width(IMG_WIDTH),
    localparam int ROW_W     = cnt_width(IMG_HEIGHT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

    // Advance one pixel per increment; column wraps into the next row, and
    // the whole position returns to the origin after the last pixel.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (inc) begin
            if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= last ? '0 : row_reg + ROW_W'(1);
            end else begin
                col_reg <= col_reg + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// 3x3 sliding-window sequencer. Accepts a raster pixel stream, drives the
// window generator's shift enable, and flags the cycles in which the nine
// taps hold a complete in-image window, with backpressure from the MAC.
module conv_window_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int COL_W      = cnt_width(IMG_WIDTH),
    parameter int ROW_W      = cnt_width(IMG_HEIGHT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             shift_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    ctrl_state_t      state_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             win_valid_reg;
    logic [ROW_W-1:0] win_row_reg;
    logic [COL_W-1:0] win_col_reg;

    logic [ROW_W-1:0] pos_row;
    logic [COL_W-1:0] pos_col;
    logic             pos_last;

    logic accept;
    logic consume;
    logic qualify;
    logic frame_start;

    // A pending window blocks new pixels unless it is being consumed now, so
    // the taps never move under a stalled window.
    assign pix_ready   = (state_reg == S_RUN) && (!win_valid_reg || win_ready);
    assign accept      = pix_valid && pix_ready;
    assign consume     = win_valid_reg && win_ready;
    assign frame_start = (state_reg == S_IDLE) && start;
    // Pixel (r,c) completes a window only once two full rows and two columns
    // precede it; this also masks row-wrap and stale line-buffer contents.
    assign qualify     = accept && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

    assign shift_en   = accept;
    assign win_valid  = win_valid_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    raster_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (frame_start),
        .inc  (accept),
        .row  (pos_row),
        .col  (pos_col),
        .last (pos_last)
    );

    // Frame sequencing with registered busy / frame_done flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    frame_done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= S_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept && pos_last) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (consume) begin
                        state_reg      <= S_DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg      <= S_IDLE;
                    busy_reg       <= 1'b0;
                    frame_done_reg <= 1'b0;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    busy_reg       <= 1'b0;
                    frame_done_reg <= 1'b0;
                end
            endcase
        end
    end

    // Window flag and output-map coordinates, aligned with the generator's
    // taps: set the cycle after the qualifying pixel is shifted in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            win_valid_reg <= 1'b0;
            win_row_reg   <= '0;
            win_col_reg   <= '0;
        end else if (qualify) begin
            win_valid_reg <= 1'b1;
            win_row_reg   <= pos_row - ROW_W'(2);
            win_col_reg   <= pos_col - COL_W'(2);
        end else if (consume) begin
            win_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: a 5x4 instance exercised with
// randomized traffic against a frame-level reference model, plus a default
// 28x28 instance run over one full frame.
module tb_conv_window_ctrl;

    localparam int SW = 5;
    localparam int SH = 4;
    localparam int SCW = 3;
    localparam int SRW = 2;
    localparam int BW = 28;
    localparam int BH = 28;
    localparam int BCW = 5;
    localparam int BRW = 5;

    logic CLK = 1'b0;
    logic RST;

    // small instance
    logic           start, pix_valid, win_ready;
    logic           pix_ready, shift_en, win_valid, busy, frame_done;
    logic [SRW-1:0] win_row;
    logic [SCW-1:0] win_col;

    // default-size instance
    logic           b_start, b_pix_valid, b_win_ready;
    logic           b_pix_ready, b_shift_en, b_win_valid, b_busy, b_frame_done;
    logic [BRW-1:0] b_win_row;
    logic [BCW-1:0] b_win_col;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: frame phase (0 idle, 1 run, 2 drain, 3 done), pixels
    // accepted this frame, window pending flag, windows consumed this frame
    int m_phase = 0;
    int m_acc   = 0;
    bit m_valid = 1'b0;
    int m_win   = 0;

    always #5 CLK = ~CLK;

    conv_window_ctrl #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .shift_en   (shift_en),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    conv_window_ctrl dut_big (
        .CLK        (CLK),
        .RST        (RST),
        .start      (b_start),
        .pix_valid  (b_pix_valid),
        .pix_ready  (b_pix_ready),
        .shift_en   (b_shift_en),
        .win_valid  (b_win_valid),
        .win_ready  (b_win_ready),
        .win_row    (b_win_row),
        .win_col    (b_win_col),
        .busy       (b_busy),
        .frame_done (b_frame_done)
    );

    // expected {pix_ready, shift_en, win_valid, busy, frame_done}
    function automatic logic [4:0] exp_flags(input logic pv, input logic wr);
        logic pr;
        pr = (m_phase == 1) && (!m_valid || wr);
        return {pr, pv && pr, m_valid, m_phase != 0, m_phase == 3};
    endfunction

    function automatic logic [SRW+SCW-1:0] exp_coords();
        return {SRW'(m_win / (SW - 2)), SCW'(m_win % (SW - 2))};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_acc   = 0;
        m_valid = 1'b0;
        m_win   = 0;
    endtask

    // advance the model across one clock edge with the given inputs
    task automatic model_step(input logic pv, input logic wr, input logic st);
        logic pr, acc, cons, qual;
        int r, c;
        pr   = (m_phase == 1) && (!m_valid || wr);
        acc  = pv && pr;
        cons = m_valid && wr;
        qual = 1'b0;
        case (m_phase)
            0: if (st) begin m_phase = 1; m_acc = 0; m_win = 0; end
            1: if (acc) begin
                r = m_acc / SW;
                c = m_acc % SW;
                qual = (r >= 2) && (c >= 2);
                m_acc++;
                if (m_acc == SW * SH) m_phase = 2;
            end
            2: if (cons) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (cons) begin
            $display("window %0d consumed (row %0d col %0d)", m_win, m_win / (SW - 2), m_win % (SW - 2));
            m_win++;
        end
        if (qual) m_valid = 1'b1;
        else if (cons) m_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        b_start = 1'b1; b_pix_valid = 1'b1; b_win_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0; start = 1'b0; b_start = 1'b0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if ({pix_ready, shift_en, win_valid, busy, frame_done, win_row, win_col} !== '0)
            $display("FAIL reset_small: got %b want all zero", {pix_ready, shift_en, win_valid, busy, frame_done, win_row, win_col});
        else n_pass++;
        n_checks++;
        if ({b_pix_ready, b_shift_en, b_win_valid, b_busy, b_frame_done, b_win_row, b_win_col} !== '0)
            $display("FAIL reset_big: got %b want all zero", {b_pix_ready, b_shift_en, b_win_valid, b_busy, b_frame_done, b_win_row, b_win_col});
        else n_pass++;
        b_pix_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // one full frame on the small instance; wr_mode 0 = always ready,
    // 1 = random ready, 2 = ready held low for 6 cycles at the first window
    task automatic test_frame(input string name, input int pv_pct, input int wr_mode);
        logic [4:0] ef;
        logic pv, wr, st;
        int f_acc, f_win, f_done, stall_left;
        bit stalled, finished;
        f_acc = 0; f_win = 0; f_done = 0; stall_left = 0; stalled = 0; finished = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            st = (cyc == 0) || ($urandom_range(0, 9) == 0);
            pv = ($urandom_range(1, 100) <= pv_pct);
            if (wr_mode == 2 && !stalled && m_valid) begin
                stalled = 1;
                stall_left = 6;
            end
            if (wr_mode == 1) wr = $urandom_range(0, 1);
            else wr = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            start = st; pix_valid = pv; win_ready = wr;
            @(negedge CLK);
            ef = exp_flags(pv, wr);
            n_checks++;
            if ({pix_ready, shift_en, win_valid, busy, frame_done} !== ef)
                $display("FAIL %s flags cyc %0d: got %b want %b (pix_ready shift_en win_valid busy frame_done)", name, cyc, {pix_ready, shift_en, win_valid, busy, frame_done}, ef);
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({win_row, win_col} !== exp_coords())
                    $display("FAIL %s coords cyc %0d: got row %0d col %0d want row %0d col %0d", name, cyc, win_row, win_col, m_win / (SW - 2), m_win % (SW - 2));
                else n_pass++;
            end
            if (shift_en) f_acc++;
            if (win_valid && win_ready) f_win++;
            if (frame_done) f_done++;
            model_step(pv, wr, st);
            @(posedge CLK);
            #1;
            if (cyc > 0 && m_phase == 0) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
        n_checks++;
        if (!finished) $display("FAIL %s timeout: frame not finished within 400 cycles", name);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({f_acc, f_win, f_done} !== {32'd20, 32'd6, 32'd1})
            $display("FAIL %s counts: got acc %0d win %0d done %0d want 20 6 1", name, f_acc, f_win, f_done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_after: got %b want 0", name, busy);
        else n_pass++;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_idle_ignored();
        logic wr;
        for (int i = 0; i < 6; i++) begin
            wr = $urandom_range(0, 1);
            start = 1'b0; pix_valid = 1'b1; win_ready = wr;
            @(negedge CLK);
            n_checks++;
            if ({pix_ready, shift_en, win_valid, busy, frame_done} !== 5'b0)
                $display("FAIL idle_ignored cyc %0d: got %b want 00000", i, {pix_ready, shift_en, win_valid, busy, frame_done});
            else n_pass++;
            model_step(1'b1, wr, 1'b0);
            @(posedge CLK);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [4:0] ef;
        int cyc;
        cyc = 0;
        while (!(m_phase == 1 && m_acc == 13) && cyc < 100) begin
            start = (cyc == 0); pix_valid = 1'b1; win_ready = 1'b1;
            @(negedge CLK);
            ef = exp_flags(1'b1, 1'b1);
            n_checks++;
            if ({pix_ready, shift_en, win_valid, busy, frame_done} !== ef)
                $display("FAIL mid_reset_pre cyc %0d: got %b want %b", cyc, {pix_ready, shift_en, win_valid, busy, frame_done}, ef);
            else n_pass++;
            model_step(1'b1, 1'b1, start);
            @(posedge CLK);
            #1;
            cyc++;
        end
        n_checks++;
        if (win_valid !== 1'b1) $display("FAIL mid_reset_window_pending: got %b want 1", win_valid);
        else n_pass++;
        RST = 1'b1; start = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if ({pix_ready, shift_en, win_valid, busy, frame_done, win_row, win_col} !== '0)
            $display("FAIL mid_reset_outputs: got %b want all zero", {pix_ready, shift_en, win_valid, busy, frame_done, win_row, win_col});
        else n_pass++;
        @(posedge CLK);
        #1;
        pix_valid = 1'b0;
        test_frame("after_reset", 100, 0);
    endtask

    task automatic test_default_frame();
        int na, nw, nd, lr, lc;
        bit seen;
        na = 0; nw = 0; nd = 0; lr = -1; lc = -1; seen = 0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            b_start = (cyc == 0);
            b_pix_valid = ($urandom_range(0, 3) != 0);
            b_win_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            if (b_shift_en) na++;
            if (b_win_valid && !b_win_ready) begin
                n_checks++;
                if (b_pix_ready !== 1'b0) $display("FAIL big_stall cyc %0d: pix_ready %b want 0", cyc, b_pix_ready);
                else n_pass++;
            end
            if (b_win_valid && b_win_ready) begin
                n_checks++;
                if ({b_win_row, b_win_col} !== {BRW'(nw / (BW - 2)), BCW'(nw % (BW - 2))})
                    $display("FAIL big_coords win %0d: got row %0d col %0d want row %0d col %0d", nw, b_win_row, b_win_col, nw / (BW - 2), nw % (BW - 2));
                else n_pass++;
                lr = b_win_row; lc = b_win_col;
                nw++;
            end
            if (b_frame_done) begin nd++; seen = 1; end
            @(posedge CLK);
            #1;
        end
        b_start = 1'b0; b_pix_valid = 1'b0; b_win_ready = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (b_frame_done) nd++;
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        n_checks++;
        if (!seen) $display("FAIL big_timeout: no frame_done within 20000 cycles");
        else n_pass++;
        n_checks++;
        if ({na, nw, nd} !== {32'd784, 32'd676, 32'd1})
            $display("FAIL big_counts: got acc %0d win %0d done %0d want 784 676 1", na, nw, nd);
        else n_pass++;
        n_checks++;
        if ({lr, lc} !== {32'd25, 32'd25}) $display("FAIL big_last_window: got (%0d,%0d) want (25,25)", lr, lc);
        else n_pass++;
        n_checks++;
        if (b_busy !== 1'b0) $display("FAIL big_busy_after: got %b want 0", b_busy);
        else n_pass++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_frame("stream", 100, 0);
        test_frame("gaps", 50, 0);
        test_frame("backpressure", 100, 2);
        test_frame("random_ready", 50, 1);
        test_idle_ignored();
        test_mid_reset();
        test_default_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
